// File: rtl/bitserial_sub_pkg.sv
// bitserial_sub_pkg: shared filter package with the serial-subtractor FSM encoding and default width
package bitserial_sub_pkg;
  localparam int DEF_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bitserial_sub_fsub.sv
// fsub: one-bit full subtractor cell, sso = sain - sbin - scin, sco = borrow out
module fsub (
  input  logic sain,
  input  logic sbin,
  input  logic scin,
  output logic sso,
  output logic sco
);
  assign sso = sain ^ sbin ^ scin;
  assign sco = (~sain & sbin) | (~(sain ^ sbin) & scin);
endmodule

// File: rtl/bitserial_sub.sv
// bitserial_sub: LSB-first serial subtractor e = d - y with borrow and signed overflow flags
module bitserial_sub
  import bitserial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] e_out,
  output logic             borrow_out,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] a, b, r;
  logic [CW-1:0] cnt;
  logic bf, diff, borrow, accept, last;
  fsub u_fsub (.sain(a[0]), .sbin(b[0]), .scin(bf), .sso(diff), .sco(borrow));
  assign accept = start && state != SHIFT;
  assign last = state == SHIFT && cnt == CW'(WIDTH - 1);
  assign busy = state == SHIFT;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: start wins outside SHIFT, DONE lasts one cycle
  always_comb begin
    nxt = state;
    nxt = accept ? SHIFT : last ? DONE : state == DONE ? IDLE : state;
  end
  // operand capture, bit-serial shifting, and result publication on the last bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      r <= '0;
      bf <= 1'b0;
      cnt <= '0;
      e_out <= '0;
      borrow_out <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      a <= d_in;
      b <= y_in;
      bf <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      a <= a >> 1;
      b <= b >> 1;
      r <= {diff, r[WIDTH-1:1]};
      bf <= borrow;
      cnt <= cnt + 1'b1;
      if (last) begin
        e_out <= {diff, r[WIDTH-1:1]};
        borrow_out <= borrow;
        ovf <= (a[0] ^ b[0]) & (diff ^ a[0]);
      end
    end
endmodule

// File: tb/tb_bitserial_sub.sv
// tb_bitserial_sub: directed table-driven checks of bitserial_sub at WIDTH=16
module tb_bitserial_sub;
  import bitserial_sub_pkg::*;
  typedef struct {
    logic [15:0] d, y, e;
    logic bo, ov;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [15:0] d_in = 0, y_in = 0, e_out;
  logic busy, done, borrow_out, ovf;
  int checks = 0, errors = 0;
  vec_t tv[10];

  bitserial_sub #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d_in(d_in), .y_in(y_in),
    .busy(busy), .done(done), .e_out(e_out), .borrow_out(borrow_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    logic [15:0] prev;
    int lat, bc;
    bit held;
    @(negedge clk);
    prev = e_out;
    d_in = v.d;
    y_in = v.y;
    start = 1;
    lat = 0;
    bc = 0;
    held = 1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 0;
        d_in = 16'($urandom);
        y_in = 16'($urandom);
      end
      if (lat == 5) start = 1;
      if (lat == 6) start = 0;
      if (!done) begin
        bc += int'(busy);
        if (e_out !== prev) held = 0;
      end
    end while (!done && lat < 40);
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " latency"}, lat, 17);
    chk({tag, " busy cycles"}, bc, 16);
    chk({tag, " e_out held"}, 32'(held), 1);
    chk({tag, " e_out"}, e_out, v.e);
    chk({tag, " borrow"}, 32'(borrow_out), 32'(v.bo));
    chk({tag, " ovf"}, 32'(ovf), 32'(v.ov));
    chk({tag, " busy in done"}, 32'(busy), 0);
    @(negedge clk);
    chk({tag, " done width"}, 32'(done), 0);
    chk({tag, " e_out hold"}, e_out, v.e);
  endtask

  initial begin
    int lat;
    tv[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
    tv[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
    tv[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    tv[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
    tv[4] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
    tv[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tv[6] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    tv[7] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b1};
    tv[8] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    tv[9] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset e_out", e_out, 0);
    chk("reset borrow", 32'(borrow_out), 0);
    chk("reset ovf", 32'(ovf), 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle busy", 32'(busy), 0);
    for (int i = 0; i < 10; i++) run_op(tv[i], $sformatf("vec%0d", i));
    @(negedge clk);
    start = 1;
    d_in = tv[0].d;
    y_in = tv[0].y;
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (lat == 1) begin
          d_in = 16'($urandom);
          y_in = 16'($urandom);
        end
      end while (!done && lat < 40);
      chk($sformatf("b2b%0d latency", k), lat, 17);
      chk($sformatf("b2b%0d e_out", k), e_out, tv[k].e);
      chk($sformatf("b2b%0d ovf", k), 32'(ovf), 32'(tv[k].ov));
      if (k < 3) begin
        d_in = tv[k+1].d;
        y_in = tv[k+1].y;
      end else start = 0;
    end
    @(negedge clk);
    chk("b2b end done", 32'(done), 0);
    d_in = 16'h0005;
    y_in = 16'h0003;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    chk("pre-abort busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("abort busy", 32'(busy), 0);
    chk("abort e_out", e_out, 0);
    chk("abort borrow", 32'(borrow_out), 0);
    chk("abort ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) lat++;
    end
    chk("post-abort idle", lat, 0);
    chk("post-abort e_out", e_out, 0);
    run_op(tv[4], "after abort");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
